mbisr_repair_analyzer: RTL

- Built-in repair analysis stage directly upstream of the memory's MBISR repair register.
- Watches BIST compare failures for one 1024x22 memory with 2 spare rows and allocates the spares to failing addresses.
- Drives the 22-bit repair word into the repair register's parallel D input, where it is captured while SE is low.
- Flags the memory as unrepairable when a third distinct failing address appears.

---
 rtl/mbisr_repair_pkg.sv | 24 ++
 rtl/mbisr_repair_slot.sv | 36 +++
 rtl/mbisr_repair_analyzer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mbisr_repair_pkg.sv
// mbisr_repair_pkg: shared constants, slot/state types and repair-word packing
// for the MBISR repair analyzer (1024x22 memory, 2 spare rows).
package mbisr_repair_pkg;

   localparam int ADDR_W     = 10;
   localparam int NUM_SPARES = 2;
   localparam int SLOT_W     = ADDR_W + 1;
   localparam int REPAIR_W   = NUM_SPARES * SLOT_W;
   localparam int FAIL_CNT_W = 4;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
   } repair_slot_t;

   typedef enum logic [1:0] {IDLE, ANALYZE, DONE} analyzer_state_e;

   // Repair register layout: {slot1_en, slot1_addr, slot0_en, slot0_addr}
   function automatic logic [REPAIR_W-1:0] pack_repair_word(input repair_slot_t slot1,
                                                            input repair_slot_t slot0);
      return {slot1, slot0};
   endfunction

endpackage

// File: rtl/mbisr_repair_slot.sv
// mbisr_repair_slot: one spare-row slot register {en, addr} with a compare
// output used for duplicate detection. A disabled slot always holds address 0.
module mbisr_repair_slot
   import mbisr_repair_pkg::*;
(
   input  logic              CLK,
   input  logic              RSTB,
   input  logic              clear,
   input  logic              load,
   input  logic [SLOT_W-1:0] load_val,
   input  logic [ADDR_W-1:0] cmp_addr,
   output logic [SLOT_W-1:0] slot_q,
   output logic              match
);

   repair_slot_t slot_r;
   repair_slot_t slot_in;

   assign slot_in = load_val;

   // Slot register; address is forced to 0 whenever the enable is not set
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         slot_r <= '0;
      end else if (clear) begin
         slot_r <= '0;
      end else if (load) begin
         slot_r.en   <= slot_in.en;
         slot_r.addr <= slot_in.en ? slot_in.addr : '0;
      end
   end

   assign slot_q = slot_r;
   assign match  = slot_r.en && (slot_r.addr == cmp_addr);

endmodule

// File: rtl/mbisr_repair_analyzer.sv
// mbisr_repair_analyzer: built-in repair analysis feeding the MBISR repair
// register D input. Allocates failing addresses to spare rows in slot0, slot1
// order and flags the memory unrepairable on a third distinct address.
// Optional macro MBISR_ANALYZER_PRELOAD_EN adds preload of a previous repair
// word (from the repair register Q) while in IDLE. A preload cycle ignores
// any simultaneous fail_valid / bist_done.
module mbisr_repair_analyzer
   import mbisr_repair_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RSTB,
   input  logic                  clear,
   input  logic                  fail_valid,
   input  logic [ADDR_W-1:0]     fail_addr,
   input  logic                  bist_done,
`ifdef MBISR_ANALYZER_PRELOAD_EN
   input  logic                  preload_valid,
   input  logic [REPAIR_W-1:0]   preload_word,
`endif
   output logic [REPAIR_W-1:0]   repair_word,
   output logic                  unrepairable,
   output logic                  analysis_done,
   output logic [FAIL_CNT_W-1:0] fail_count
);

   analyzer_state_e state_q, state_d;

   logic [NUM_SPARES-1:0][SLOT_W-1:0] slot_q;
   logic [NUM_SPARES-1:0][SLOT_W-1:0] load_val;
   logic [NUM_SPARES-1:0]             load;
   logic [NUM_SPARES-1:0]             match;
   logic                              pre_ld;
   logic                              accept;
   logic                              fresh;
   logic                              overflow;
   repair_slot_t                      slot0, slot1;

   assign slot0 = slot_q[0];
   assign slot1 = slot_q[1];

`ifdef MBISR_ANALYZER_PRELOAD_EN
   assign pre_ld = preload_valid && (state_q == IDLE) && !clear;
`else
   assign pre_ld = 1'b0;
`endif

   // A failure is taken unless we are frozen, restarting or preloading
   assign accept   = fail_valid && !clear && !pre_ld && (state_q != DONE);
   assign fresh    = accept && !(|match);
   assign overflow = fresh && slot0.en && slot1.en;

   // Slot load selection: preload copies the old word, else priority allocation
   always_comb begin
      load     = '0;
      load_val = '0;
      for (int i = 0; i < NUM_SPARES; i++) begin
`ifdef MBISR_ANALYZER_PRELOAD_EN
         load_val[i] = pre_ld ? preload_word[i*SLOT_W +: SLOT_W] : {1'b1, fail_addr};
`else
         load_val[i] = {1'b1, fail_addr};
`endif
      end
      load[0] = pre_ld || (fresh && !slot0.en);
      load[1] = pre_ld || (fresh && slot0.en && !slot1.en);
   end

   for (genvar g = 0; g < NUM_SPARES; g++) begin : g_slot
      mbisr_repair_slot u_slot (
         .CLK      (CLK),
         .RSTB     (RSTB),
         .clear    (clear),
         .load     (load[g]),
         .load_val (load_val[g]),
         .cmp_addr (fail_addr),
         .slot_q   (slot_q[g]),
         .match    (match[g])
      );
   end

   // State register
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state; a bist_done in IDLE freezes immediately after that cycle's event
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (!pre_ld) begin
                  if (bist_done)       state_d = DONE;
                  else if (fail_valid) state_d = ANALYZE;
               end
            end
            ANALYZE: if (bist_done) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Sticky unrepairable flag and saturating fail counter
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         unrepairable <= 1'b0;
         fail_count   <= '0;
      end else if (clear) begin
         unrepairable <= 1'b0;
         fail_count   <= '0;
      end else begin
         if (overflow) unrepairable <= 1'b1;
         if (accept && (fail_count != '1)) fail_count <= fail_count + 1'b1;
      end
   end

   assign repair_word   = pack_repair_word(slot1, slot0);
   assign analysis_done = (state_q == DONE);

endmodule
